// File: rtl/sfq_dff_bank.sv
// Clocked bank of N RSFQ DFF timing models sharing one toggle-encoded readout line.
// Timing violations set sticky per-channel flags and bump a saturating counter.
module sfq_dff_bank #(
  parameter int N       = 4,
  parameter int DELAY   = 5,
  parameter int CT0     = 1,
  parameter int CT1     = 3,
  parameter int NDRO    = 0,
  parameter int STARTUP = 4,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  set,
  input  logic          rd,
  input  logic          clr_err,
  output logic [N-1:0]  out,
  output logic [N-1:0]  err,
  output logic [CW-1:0] err_count
);

  localparam int SUW = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;
  localparam int NCW = $clog2(N + 1);
  localparam int SW  = CW + NCW;

  // Number of channels violating in one cycle.
  function automatic logic [NCW-1:0] pop_count(input logic [N-1:0] v);
    logic [NCW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + NCW'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [NCW-1:0] b);
    logic [SW-1:0] sum;
    logic [CW-1:0] res;
    sum = SW'(a) + SW'(b);
    if (sum > SW'({CW{1'b1}})) begin
      res = {CW{1'b1}};
    end else begin
      res = sum[CW-1:0];
    end
    return res;
  endfunction

  logic [N-1:0]   set_q_r;
  logic           rd_q_r;
  logic [SUW-1:0] su_cnt_r;
  logic [N-1:0]   state_r;
  logic [3:0]     win_r [N];
  logic [N-1:0]   pipe_r [DELAY];
  logic [N-1:0]   out_r;
  logic [N-1:0]   err_r;
  logic [CW-1:0]  cnt_r;

  logic           active_s;
  logic           rd_p_s;
  logic [N-1:0]   set_p_s;
  logic [N-1:0]   state_nxt_s;
  logic [3:0]     win_nxt_s [N];
  logic [N-1:0]   fire_s;
  logic [N-1:0]   viol_s;
  logic [N-1:0]   err_nxt_s;
  logic [CW-1:0]  cnt_nxt_s;

  assign active_s = (su_cnt_r >= SUW'(STARTUP));
  assign rd_p_s   = active_s & (rd ^ rd_q_r);
  assign set_p_s  = {N{active_s}} & (set ^ set_q_r);

  // Per-channel readout first on the old state, then set checked against the resulting window.
  always_comb begin
    state_nxt_s = state_r;
    fire_s      = '0;
    viol_s      = '0;
    for (int i = 0; i < N; i++) begin
      win_nxt_s[i] = 4'd0;
      if (rd_p_s) begin
        win_nxt_s[i]   = state_r[i] ? 4'(CT1) : 4'(CT0);
        fire_s[i]      = state_r[i];
        state_nxt_s[i] = (NDRO != 0) ? state_r[i] : 1'b0;
      end else if (win_r[i] != 4'd0) begin
        win_nxt_s[i] = win_r[i] - 4'd1;
      end else begin
        win_nxt_s[i] = 4'd0;
      end
      if (set_p_s[i]) begin
        if (win_nxt_s[i] != 4'd0) begin
          viol_s[i] = 1'b1;
        end else begin
          state_nxt_s[i] = 1'b1;
        end
      end else begin
        viol_s[i] = 1'b0;
      end
    end
  end

  // Error flags and counter; a same-cycle violation survives clr_err.
  always_comb begin
    err_nxt_s = err_r;
    cnt_nxt_s = cnt_r;
    if (clr_err) begin
      err_nxt_s = viol_s;
      cnt_nxt_s = sat_add({CW{1'b0}}, pop_count(viol_s));
    end else begin
      err_nxt_s = err_r | viol_s;
      cnt_nxt_s = sat_add(cnt_r, pop_count(viol_s));
    end
  end

  // Edge-detect history and startup blanking counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q_r  <= '0;
      rd_q_r   <= 1'b0;
      su_cnt_r <= '0;
    end else begin
      set_q_r <= set;
      rd_q_r  <= rd;
      if (!active_s) begin
        su_cnt_r <= su_cnt_r + SUW'(1);
      end else begin
        su_cnt_r <= su_cnt_r;
      end
    end
  end

  // Channel state, critical windows, output delay line and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= '0;
      out_r   <= '0;
      err_r   <= '0;
      cnt_r   <= '0;
      for (int i = 0; i < N; i++) begin
        win_r[i] <= 4'd0;
      end
      for (int j = 0; j < DELAY; j++) begin
        pipe_r[j] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      err_r   <= err_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= out_r ^ pipe_r[DELAY-1];
      for (int i = 0; i < N; i++) begin
        win_r[i] <= win_nxt_s[i];
      end
      pipe_r[0] <= fire_s;
      for (int j = 1; j < DELAY; j++) begin
        pipe_r[j] <= pipe_r[j-1];
      end
    end
  end

  assign out       = out_r;
  assign err       = err_r;
  assign err_count = cnt_r;

endmodule

// File: tb/tb_sfq_dff_bank.sv
// Bench for sfq_dff_bank: two differently configured instances share random and directed
// stimulus and are compared every cycle against an event-time reference model.
module tb_sfq_dff_bank;

  localparam int N = 4;
  localparam int STARTUP = 4;
  localparam int M_DLY  [2] = '{5, 3};
  localparam int M_CT0  [2] = '{1, 0};
  localparam int M_CT1  [2] = '{3, 2};
  localparam int M_NDRO [2] = '{0, 1};
  localparam int M_MAX  [2] = '{255, 15};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] set_v = '0;
  logic         rd_v = 1'b0;
  logic         clr_v = 1'b0;
  logic [N-1:0] out0, err0, out1, err1;
  logic [7:0]   cnt0;
  logic [3:0]   cnt1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: readout times schedule toggles in a time-indexed table,
  // sets are rejected while the edge index is before the readout's block time.
  bit [N-1:0] m_state [2];
  bit [N-1:0] m_out   [2];
  bit [N-1:0] m_err   [2];
  int         m_cnt   [2];
  int         m_block [2][N];
  bit [N-1:0] m_tog   [2][64];
  bit [N-1:0] m_set_prev;
  bit         m_rd_prev;
  int         m_e;

  always #5 clk = ~clk;

  sfq_dff_bank #(.N(N), .DELAY(5), .CT0(1), .CT1(3), .NDRO(0), .STARTUP(STARTUP), .CW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .set(set_v), .rd(rd_v), .clr_err(clr_v),
    .out(out0), .err(err0), .err_count(cnt0)
  );

  sfq_dff_bank #(.N(N), .DELAY(3), .CT0(0), .CT1(2), .NDRO(1), .STARTUP(STARTUP), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .set(set_v), .rd(rd_v), .clr_err(clr_v),
    .out(out1), .err(err1), .err_count(cnt1)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e = 0;
    m_set_prev = '0;
    m_rd_prev = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_state[m] = '0;
      m_out[m] = '0;
      m_err[m] = '0;
      m_cnt[m] = 0;
      for (int i = 0; i < N; i++) m_block[m][i] = 0;
      for (int t = 0; t < 64; t++) m_tog[m][t] = '0;
    end
  endtask

  task automatic model_step();
    bit [N-1:0] sp;
    bit         rp;
    bit [N-1:0] viol;
    int         nv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sp = set_v ^ m_set_prev;
    rp = rd_v ^ m_rd_prev;
    m_set_prev = set_v;
    m_rd_prev = rd_v;
    for (int m = 0; m < 2; m++) begin
      m_out[m] ^= m_tog[m][m_e % 64];
      m_tog[m][m_e % 64] = '0;
      viol = '0;
      nv = 0;
      if (m_e >= STARTUP) begin
        for (int i = 0; i < N; i++) begin
          if (rp) begin
            if (m_state[m][i]) begin
              m_tog[m][(m_e + M_DLY[m]) % 64][i] = 1'b1;
              if (M_NDRO[m] == 0) m_state[m][i] = 1'b0;
              m_block[m][i] = m_e + M_CT1[m];
            end else begin
              m_block[m][i] = m_e + M_CT0[m];
            end
          end
          if (sp[i]) begin
            if (m_e < m_block[m][i]) begin
              viol[i] = 1'b1;
              nv++;
            end else begin
              m_state[m][i] = 1'b1;
            end
          end
        end
      end
      if (clr_v) begin
        m_err[m] = viol;
        m_cnt[m] = (nv > M_MAX[m]) ? M_MAX[m] : nv;
      end else begin
        m_err[m] |= viol;
        m_cnt[m] = (m_cnt[m] + nv > M_MAX[m]) ? M_MAX[m] : m_cnt[m] + nv;
      end
    end
    m_e++;
  endtask

  task automatic compare_all();
    check_val("out0", int'(out0), int'(m_out[0]));
    check_val("err0", int'(err0), int'(m_err[0]));
    check_val("cnt0", int'(cnt0), m_cnt[0]);
    check_val("out1", int'(out1), int'(m_out[1]));
    check_val("err1", int'(err1), int'(m_err[1]));
    check_val("cnt1", int'(cnt1), m_cnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check_val("reset_out0", int'(out0), 0);
    check_val("reset_cnt0", int'(cnt0), 0);
    rst_n = 1'b1;

    // Directed: edge c is the c-th rising edge after reset release.
    for (int c = 0; c < 40; c++) begin
      case (c)
        2:  set_v[3] = ~set_v[3];
        10: set_v[1:0] = ~set_v[1:0];
        20: rd_v = ~rd_v;
        21: set_v[2] = ~set_v[2];
        22: set_v[1] = ~set_v[1];
        30: rd_v = ~rd_v;
        default: ;
      endcase
      tick();
      if (c == 24) check_val("out0_b0_before", int'(out0[0]), 0);
      if (c == 25) check_val("out0_b0_at25", int'(out0[0]), 1);
    end
    check_val("dir_out0", int'(out0), 4'b0111);
    check_val("dir_err0", int'(err0), 4'b0010);
    check_val("dir_cnt0", int'(cnt0), 1);

    // Saturation: readout and set on every channel every cycle.
    for (int c = 0; c < 75; c++) begin
      rd_v = ~rd_v;
      set_v = ~set_v;
      tick();
    end
    check_val("sat_cnt0", int'(cnt0), 255);
    check_val("sat_err0", int'(err0), 4'hF);
    clr_v = 1'b1;
    tick();
    clr_v = 1'b0;
    check_val("clr_cnt0", int'(cnt0), 0);
    check_val("clr_err0", int'(err0), 0);

    // Random traffic with occasional clears and asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_v[i] = ~set_v[i];
      end
      if ($urandom_range(0, 5) == 0) rd_v = ~rd_v;
      clr_v = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rand_rst_out0", int'(out0), 0);
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    clr_v = 1'b0;

    // Reset with a toggle still in flight: nothing may emerge afterwards.
    repeat (6) tick();
    set_v[0] = ~set_v[0];
    tick();
    rd_v = ~rd_v;
    repeat (2) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("midrst_out0", int'(out0), 0);
    check_val("midrst_err0", int'(err0), 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check_val("post_rst_out0", int'(out0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
